// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the unified I/D memory arbiter
// Ports: none (package). Holds the FSM state type, the grant owner type and
// the latched memory request record. MEM_IDX_W is wide enough for any
// doubleword index the arbiter can be built for (byte address up to 32 bits).
package mem_arb_pkg;

  localparam int unsigned MEM_IDX_W = 29;

  typedef enum logic [1:0] {ARB_IDLE, ARB_I_ACC, ARB_D_ACC, ARB_RESP} arb_state_e;

  typedef enum logic {OWN_I, OWN_D} owner_e;

  typedef struct packed {
    logic                 we;
    logic [MEM_IDX_W-1:0] addr;
    logic [63:0]          wdata;
  } mem_req_t;

endpackage

// File: rtl/unified_mem_arbiter_starve.sv
// rtl/unified_mem_arbiter_starve.sv - saturating starvation counter for the fetch requester
// Ports:
//   clk, reset_b : clock, synchronous active-low reset
//   i_inc        : count one data grant made while a fetch was waiting
//   i_clr        : clear (fetch granted, or fetch not requesting while idle)
//   o_sat        : counter has reached MAX_COUNT
module arb_starve_counter #(
  parameter int unsigned MAX_COUNT = 4,
  parameter int unsigned CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic reset_b,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_COUNT);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_sat = (r_cnt == LP_MAX);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one 64-bit single-ported memory between fetch (I) and data (D)
// Ports:
//   clk, reset_b                       : clock, synchronous active-low reset
//   i_req/i_addr -> i_rdata/i_valid    : fetch requester, 32-bit word from a doubleword
//   i_stall                            : i_req & ~i_valid
//   d_req/d_we/d_addr/d_wdata          : data requester (load or store)
//   d_rdata/d_valid, d_stall           : load data, completion pulse, d_req & ~d_valid
//   m_req/m_we/m_addr/m_wdata          : memory request, held until m_ack
//   m_ack/m_rdata                      : memory completion and read data (same cycle)
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int MAX_D_BURST = 4,
  parameter int CNT_WIDTH   = $clog2(MAX_D_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_valid,
  output logic                  i_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [63:0]           d_wdata,
  output logic [63:0]           d_rdata,
  output logic                  d_valid,
  output logic                  d_stall,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-4:0] m_addr,
  output logic [63:0]           m_wdata,
  input  logic                  m_ack,
  input  logic [63:0]           m_rdata
);

  arb_state_e r_state, w_state_nxt;
  mem_req_t   r_req;
  owner_e     r_owner;
  logic       r_half;
  logic       r_m_req;
  logic       r_i_valid, r_d_valid;
  logic [31:0] r_i_rdata;
  logic [63:0] r_d_rdata;

  logic w_grant_i, w_grant_d, w_acc_done, w_sat;
  // Sub-doubleword address bits are intentionally dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

  arb_starve_counter #(
    .MAX_COUNT(MAX_D_BURST),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_starve (
    .clk    (clk),
    .reset_b(reset_b),
    .i_inc  (w_grant_d & i_req),
    .i_clr  (w_grant_i | ((r_state == ARB_IDLE) & ~i_req)),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) r_state <= ARB_IDLE;
    else          r_state <= w_state_nxt;
  end

  // D has priority unless the fetch side has been passed over MAX_D_BURST times.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_acc_done  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (d_req && !(i_req && w_sat)) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ARB_D_ACC;
        end else if (i_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ARB_I_ACC;
        end
      end
      ARB_I_ACC, ARB_D_ACC: begin
        if (m_ack) begin
          w_acc_done  = 1'b1;
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  // Valid is registered on the ack edge, so it is high exactly during RESP.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_req     <= '0;
      r_owner   <= OWN_I;
      r_half    <= 1'b0;
      r_m_req   <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      if (w_grant_d) begin
        r_req   <= '{we: d_we, addr: MEM_IDX_W'(d_addr[ADDR_WIDTH-1:3]), wdata: d_wdata};
        r_owner <= OWN_D;
        r_m_req <= 1'b1;
      end else if (w_grant_i) begin
        r_req   <= '{we: 1'b0, addr: MEM_IDX_W'(i_addr[ADDR_WIDTH-1:3]), wdata: 64'd0};
        r_half  <= i_addr[2];
        r_owner <= OWN_I;
        r_m_req <= 1'b1;
      end else if (w_acc_done) begin
        r_m_req <= 1'b0;
        if (r_owner == OWN_I) begin
          r_i_rdata <= r_half ? m_rdata[63:32] : m_rdata[31:0];
          r_i_valid <= 1'b1;
        end else begin
          if (!r_req.we) r_d_rdata <= m_rdata;
          r_d_valid <= 1'b1;
        end
      end
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_req.we;
  assign m_addr  = (ADDR_WIDTH - 3)'(r_req.addr);
  assign m_wdata = r_req.wdata;
  assign i_rdata = r_i_rdata;
  assign i_valid = r_i_valid;
  assign d_rdata = r_d_rdata;
  assign d_valid = r_d_valid;
  assign i_stall = i_req & ~r_i_valid;
  assign d_stall = d_req & ~r_d_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        i_req, i_valid, i_stall;
  logic [12:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [12:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [9:0]  m_addr;
  logic [63:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_WIDTH(13), .MAX_D_BURST(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        we;
    logic [9:0]  idx;
    logic [63:0] wdata;
  } grant_t;

  grant_t      g_q[$];
  logic [31:0] i_q[$];
  logic [63:0] d_q[$];
  logic [63:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;
  int ack_delay = 0;
  logic spur_ack = 1'b0;
  logic started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_g(input logic we, input logic [9:0] idx, input logic [63:0] wdata);
    grant_t g;
    g.we = we; g.idx = idx; g.wdata = wdata;
    g_q.push_back(g);
  endtask

  // Memory responder: acks after ack_delay wait cycles; optional spurious ack when idle.
  initial begin
    int wcnt;
    wcnt = 0;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (m_req === 1'b1) begin
        if (wcnt == ack_delay) begin
          m_ack = 1'b1;
          m_rdata = mem[m_addr];
          if (m_we) mem[m_addr] = m_wdata;
          wcnt = 0;
        end else begin
          m_ack = 1'b0;
          wcnt++;
        end
      end else begin
        m_ack = spur_ack;
        m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        wcnt = 0;
      end
    end
  end

  // Monitor: checks grants against g_q and completions against i_q / d_q.
  initial begin
    grant_t cur;
    logic have_cur, prev_m_req, prev_iv, prev_dv;
    have_cur = 0; prev_m_req = 0; prev_iv = 0; prev_dv = 0;
    cur.we = 0; cur.idx = 0; cur.wdata = 0;
    forever begin
      @(negedge clk);
      if (started && reset_b === 1'b1) begin
        chk("i_stall", 64'(i_stall), 64'(i_req & ~i_valid));
        chk("d_stall", 64'(d_stall), 64'(d_req & ~d_valid));
        if (m_req === 1'b1) begin
          if (!prev_m_req) begin
            if (g_q.size() == 0) flag("unexpected_grant");
            else begin cur = g_q.pop_front(); have_cur = 1; end
          end
          if (have_cur) begin
            chk("m_we", 64'(m_we), 64'(cur.we));
            chk("m_addr", 64'(m_addr), 64'(cur.idx));
            if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
          end
        end else have_cur = 0;
        if (i_valid === 1'b1) begin
          if (prev_iv) flag("i_valid_width");
          if (i_q.size() == 0) flag("unexpected_i_valid");
          else chk("i_rdata", 64'(i_rdata), 64'(i_q.pop_front()));
        end
        if (d_valid === 1'b1) begin
          if (prev_dv) flag("d_valid_width");
          if (d_q.size() == 0) flag("unexpected_d_valid");
          else chk("d_rdata", d_rdata, d_q.pop_front());
        end
        prev_m_req = (m_req === 1'b1);
        prev_iv = (i_valid === 1'b1);
        prev_dv = (d_valid === 1'b1);
      end
    end
  end

  task automatic do_i(input logic [12:0] a, input logic [31:0] exp, output int lat);
    i_req = 1'b1; i_addr = a; i_q.push_back(exp);
    lat = 0;
    do begin @(negedge clk); lat++; end while (i_valid !== 1'b1 && lat < 60);
    if (i_valid !== 1'b1) flag("i_timeout");
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [12:0] a, input logic [63:0] wd,
                      input logic [63:0] exp, output int lat);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_q.push_back(exp);
    lat = 0;
    do begin @(negedge clk); lat++; end while (d_valid !== 1'b1 && lat < 60);
    if (d_valid !== 1'b1) flag("d_timeout");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb;
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    mem[0]  = 64'hAAAA_BBBB_1111_2222;
    mem[1]  = 64'hDEAD_BEEF_CAFE_F00D;
    mem[2]  = 64'h0123_4567_89AB_CDEF;
    mem[5]  = 64'h5555_0000_5555_0000;
    mem[32] = 64'h1111_1111_1111_1111;
    mem[33] = 64'h2222_2222_2222_2222;
    mem[34] = 64'h3333_3333_3333_3333;
    mem[35] = 64'h4444_4444_4444_4444;
    mem[36] = 64'h5555_5555_5555_5555;
    mem[64] = 64'h7777_6666_9999_8888;
    reset_b = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1; started = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_m_req", 64'(m_req), 0);
    chk("rst_m_we", 64'(m_we), 0);
    chk("rst_m_addr", 64'(m_addr), 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_valid", 64'(i_valid), 0);
    chk("rst_d_valid", 64'(d_valid), 0);
    chk("rst_i_rdata", 64'(i_rdata), 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1;

    // Lone fetch, upper half of doubleword 0
    push_g(0, 10'd0, 0);
    do_i(13'h004, 32'hAAAA_BBBB, la);
    chk("fetch_latency", 64'(la), 3);

    // Simultaneous: D load at 0x010 first, then I fetch at 0x00C
    push_g(0, 10'd2, 0);
    push_g(0, 10'd1, 0);
    fork
      do_d(0, 13'h010, 0, 64'h0123_4567_89AB_CDEF, la);
      do_i(13'h00C, 32'hDEAD_BEEF, lb);
    join
    chk("simul_d_latency", 64'(la), 3);
    chk("simul_i_latency", 64'(lb), 6);

    // Store with 3 wait cycles; d_rdata keeps the previous load value
    ack_delay = 3;
    push_g(1, 10'd3, 64'h1234);
    do_d(1, 13'h018, 64'h1234, 64'h0123_4567_89AB_CDEF, la);
    chk("store_latency", 64'(la), 6);
    ack_delay = 0;
    push_g(0, 10'd3, 0);
    do_d(0, 13'h018, 0, 64'h1234, la);
    i_addr = 13'h008;

    // Starvation: 4 D grants, then I, then D, then I
    push_g(0, 10'd32, 0); push_g(0, 10'd33, 0); push_g(0, 10'd34, 0); push_g(0, 10'd35, 0);
    push_g(0, 10'd64, 0); push_g(0, 10'd36, 0); push_g(0, 10'd64, 0);
    fork
      begin
        do_d(0, 13'h100, 0, 64'h1111_1111_1111_1111, la);
        do_d(0, 13'h108, 0, 64'h2222_2222_2222_2222, la);
        do_d(0, 13'h110, 0, 64'h3333_3333_3333_3333, la);
        do_d(0, 13'h118, 0, 64'h4444_4444_4444_4444, la);
        do_d(0, 13'h120, 0, 64'h5555_5555_5555_5555, la);
      end
      begin
        do_i(13'h200, 32'h9999_8888, lb);
        do_i(13'h204, 32'h7777_6666, lb);
      end
    join

    // Reset in the middle of a D access: abandoned, no completion expected
    ack_delay = 20;
    push_g(0, 10'd5, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 13'h028;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b0; d_req = 1'b0;
    @(posedge clk); #1 reset_b = 1'b1; ack_delay = 0;
    @(negedge clk);
    chk("rstmid_m_req", 64'(m_req), 0);
    chk("rstmid_d_valid", 64'(d_valid), 0);

    // Spurious acks while idle with no requests
    spur_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_m_req", 64'(m_req), 0);
      chk("spur_i_valid", 64'(i_valid), 0);
      chk("spur_d_valid", 64'(d_valid), 0);
      chk("spur_i_rdata", 64'(i_rdata), 0);
      chk("spur_d_rdata", d_rdata, 0);
    end
    @(posedge clk); #1 spur_ack = 1'b0;

    // Arbiter is back in IDLE: a fetch sees the nominal latency
    push_g(0, 10'd0, 0);
    do_i(13'h000, 32'h1111_2222, la);
    chk("post_rst_fetch_latency", 64'(la), 3);

    repeat (5) @(negedge clk);
    chk("grant_q_empty", 64'(g_q.size()), 0);
    chk("i_q_empty", 64'(i_q.size()), 0);
    chk("d_q_empty", 64'(d_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported 64-bit backing memory between the pipeline's instruction-fetch requester (I) and its data-access requester (D).
- Sequences each access through a small FSM and returns read data.
- Produces stall outputs that gate pc_write and the IF/ID and EX/MEM pipe registers.
- Data has fixed priority, except that a starvation counter forces one fetch grant after MAX_D_BURST consecutive data grants.

Parameters:
ADDR_WIDTH, 13, byte-address width of the I and D requesters (8 KB space).
MAX_D_BURST, 4, number of consecutive D grants allowed while I is waiting; must be at least 1.
CNT_WIDTH, $clog2(MAX_D_BURST+1), width of the starvation counter (derived; do not override).

Ports:
clk  in  1  system clock
reset_b  in  1  synchronous, active-low reset
i_req  in  1  fetch request; held high with i_addr stable until i_valid
i_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
i_rdata  out  32  fetched instruction
i_valid  out  1  one-cycle completion pulse for a fetch
i_stall  out  1  i_req & ~i_valid (combinational)
d_req  in  1  data request; held high with its fields stable until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_WIDTH  data byte address; bits [2:0] ignored
d_wdata  in  64  store data
d_rdata  out  64  load data
d_valid  out  1  one-cycle completion pulse for a data access (load or store)
d_stall  out  1  d_req & ~d_valid (combinational)
m_req  out  1  memory request; held high until m_ack
m_we  out  1  memory write enable
m_addr  out  ADDR_WIDTH-3  doubleword index (addr[ADDR_WIDTH-1:3])
m_wdata  out  64  memory write data
m_ack  in  1  memory completion; m_rdata is valid in the same cycle
m_rdata  in  64  memory read data

Behaviour:
- All state updates on posedge clk. Reset is synchronous: when reset_b=0 at an edge, the block resets.
- Reset values: state=ARB_IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0; i_valid=0, d_valid=0; i_rdata=0, d_rdata=0; starve_cnt=0.
- States and transitions:
  - ARB_IDLE to ARB_D_ACC: when d_req & ~(i_req & starve_cnt==MAX_D_BURST).
  - ARB_IDLE to ARB_I_ACC: otherwise, if i_req.
  - ARB_IDLE: otherwise stay.
- On the grant edge, the chosen requester's addr/we/wdata are latched into m_*, and m_req goes high the next cycle. For a fetch, m_we=0 and the selected word-half bit i_addr[2] is latched.
- ARB_I_ACC / ARB_D_ACC: hold m_req and all m_* fields until m_ack=1. On that edge:
  - Drop m_req.
  - Capture the result: i_rdata = latched i_addr[2] ? m_rdata[63:32] : m_rdata[31:0]; d_rdata = m_rdata for loads only (stores leave d_rdata unchanged).
  - Go to ARB_RESP.
- ARB_RESP: assert the granted requester's valid for exactly one cycle; no new grant in this cycle; then return to ARB_IDLE. The requester drops or changes its req on the same edge.
- Latency: with m_ack arriving in the first m_req cycle, the valid pulse occurs 3 cycles after req rises (grant edge, ack edge, RESP cycle). Each extra m_ack wait cycle adds 1.
- m_ack is ignored outside the ACC states. m_req is never high in IDLE or RESP.
- starve_cnt:
  - D grant with i_req=1: increment, saturating at MAX_D_BURST.
  - Any I grant, or any edge in IDLE with i_req=0: clear to 0.
- Simultaneous i_req and d_req in IDLE: D wins unless starve_cnt==MAX_D_BURST.
- Reset mid-access abandons the transaction: m_req drops next cycle and no valid pulse is issued.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_e {ARB_IDLE, ARB_I_ACC, ARB_D_ACC, ARB_RESP};
  - typedef enum logic owner_e {OWN_I, OWN_D};
  - packed struct mem_req_t {we, addr, wdata} for the latched request.
- One sub-module, arb_starve_counter: saturating counter with inc/clr inputs and a sat output.

Test Plan:
- Lone fetch: i_req, i_addr=0x004, memory acks in 1st cycle with m_rdata=0xAAAA_BBBB_1111_2222 -> m_addr=0, i_rdata=0xAAAA_BBBB, i_valid exactly 3 cycles after i_req, i_stall high until then.
- Simultaneous i_req/d_req (load at 0x010): D granted first (m_addr=2); I granted right after D's RESP cycle.
- Starvation: d_req held continuously with back-to-back requests, i_req held -> after 4 D grants, the 5th grant is I; starve_cnt returns to 0.
- Store d_we=1, d_addr=0x018, d_wdata=0x1234, m_ack delayed 3 cycles -> m_we=1, m_addr=3, m_wdata=0x1234 held stable 4 cycles; d_valid pulses once; d_rdata unchanged.
- reset_b=0 for one cycle while in ARB_D_ACC -> next cycle m_req=0, state IDLE, no d_valid; a later m_ack is ignored.
- Spurious m_ack=1 in IDLE with no requests -> no valid pulse, outputs unchanged.
